cla_addsub_pipe: RTL
====================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the team's single-cycle 4-bit CLA.
- Operands of WIDTH bits are split into 4-bit lookahead groups. Each pipeline stage resolves GROUPS_PER_STAGE groups and registers the inter-group carry.
- Valid/ready handshake on both sides with full backpressure. Sits between the operand-fetch logic and the result writeback in the datapath.

Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of 4*GROUPS_PER_STAGE.
- GROUPS_PER_STAGE, 2: 4-bit CLA groups evaluated per pipeline stage.
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- STAGES, derived, = WIDTH/(4*GROUPS_PER_STAGE): pipeline depth; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B+cin; 1 = A-B-cin (cin acts as borrow)
- cin  in  1  carry-in / borrow-in
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out (add) / not-borrow (sub), raw carry of final group
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0, zero=0, out_tag=0. in_ready=1 during reset release.
  - Reset mid-operation discards every in-flight operation; nothing emerges after reset.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = cin ^ sub.
- Stage k (0..STAGES-1):
  - Computes sum bits for groups k*GPS .. k*GPS+GPS-1 using 4-bit lookahead within each group.
  - Group-level lookahead across the GPS groups in the stage: group P/G, not ripple.
  - Registers: the resulting carry; all already-computed sum bits; the unprocessed upper operand bits; the tag; the MSB carry-in needed for ovf.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no stall. Throughput 1 operation/cycle.
- Flow control is a single global enable: adv = !out_valid | out_ready.
  - in_ready = adv (combinational from out_valid and out_ready).
  - When adv=0 every stage register holds, including valid bits; no bubble compression.
  - When adv=1 every stage shifts. Stage-0 valid loads (in_valid & in_ready).
  - A stage with valid=0 still shifts. Its data contents are don't-care, but output data registers update only when the loaded valid is 1, so sum, cout, ovf, zero and out_tag hold their last value across bubbles.
- Results:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
  - All are registered with sum.
- Simultaneous out_ready & in_valid with a full pipeline: the result is consumed and the new operation accepted in the same cycle.
- Outputs are stable while out_valid=1 and out_ready=0.
- Wrap-around: arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package (cla_pkg): constant GROUP_W=4; function computing STAGES from WIDTH and GPS; packed struct type for stage payload (sum bits, remaining a/b, carry, msb_cin, tag), parameterised via localparams in the module.
- One sub-module, cla_group4_pg: combinational 4-bit lookahead group with inputs a, b, ci and outputs s, group P, group G, carry into bit 3.
  - Instantiated GROUPS_PER_STAGE times per stage inside a generate loop.
  - Stage-level carry merge is done inline in the top module.

Test Plan (WIDTH=16, GROUPS_PER_STAGE=2, STAGES=2):
- Add: a=16'h1234, b=16'h0FF1, sub=0, cin=0, tag=3 -> 2 cycles later out_valid=1, sum=16'h2225, cout=0, ovf=0, zero=0, out_tag=3.
- Signed overflow and carry: a=16'h7FFF, b=16'h0001 add -> sum=16'h8000, ovf=1, cout=0. Then a=16'hFFFF, b=16'h0001 -> sum=0, cout=1, zero=1, ovf=0.
- Subtract with borrow: a=16'h0005, b=16'h0007, sub=1, cin=0 -> sum=16'hFFFE, cout=0. Same operands with cin=1 -> sum=16'hFFFD.
- Backpressure: stream 5 ops back-to-back with out_ready held 0 from cycle 2 to 6.
  - in_ready drops once out_valid=1.
  - Outputs hold; no op is lost or duplicated.
  - All 5 results emerge in order, tags 0..4.
- Reset mid-flight: accept 2 ops, assert rst_n=0 asynchronously between clock edges.
  - out_valid=0 and sum=0 immediately.
  - After release, no result appears until a new op is accepted, which emerges 2 cycles later.
- Randomised sweep of 10k ops with random out_ready, checked against the reference model {cout,sum} = a + (sub?~b:b) + (cin^sub).

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined CLA adder/subtractor
package cla_pkg;
  localparam int GROUP_W = 4;
  function automatic int stages_of(input int width, input int gps);
    return width / (GROUP_W * gps);
  endfunction
endpackage

// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if: operand/result handshake bundle for the CLA pipeline
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, a, b, sub, cin, in_tag, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );
  modport slave (
    input  in_valid, a, b, sub, cin, in_tag, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );
endinterface

// File: rtl/cla_group4_pg.sv
// cla_group4_pg: 4-bit carry-lookahead group with group propagate/generate
module cla_group4_pg (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       p,
  output logic       g,
  output logic       c3
);
  logic [3:0] pp, gg, c;
  assign pp = a ^ b;
  assign gg = a & b;
  assign c[0] = ci;
  assign c[1] = gg[0] | (pp[0] & ci);
  assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
  assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
  assign s = pp ^ c;
  assign p = &pp;
  assign g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
  assign c3 = c[3];
endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor, one global stall enable
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUPS_PER_STAGE = 2,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst_n,
  cla_addsub_pipe_if.slave io
);
  localparam int GPS = GROUPS_PER_STAGE;
  localparam int SW = GROUP_W * GPS;
  localparam int STAGES = stages_of(WIDTH, GPS);
  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             mc;
    logic [TAG_W-1:0] tag;
  } pay_t;
  pay_t r [STAGES];
  pay_t nxt [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES:0] vv;
  logic adv, zero_q;
  assign adv = !v[STAGES-1] | io.out_ready;
  assign vv = {v, io.in_valid};
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    pay_t pin;
    logic [GPS-1:0] gp, gg, c3;
    logic [GPS:0] gc;
    logic [SW-1:0] ss;
    if (k == 0) begin : g_in
      assign pin = '{s: '0, a: io.a, b: io.sub ? ~io.b : io.b, c: io.cin ^ io.sub, mc: 1'b0, tag: io.in_tag};
    end else begin : g_mid
      assign pin = r[k-1];
    end
    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group4_pg u_grp (
        .a (pin.a[LO+GROUP_W*j +: GROUP_W]),
        .b (pin.b[LO+GROUP_W*j +: GROUP_W]),
        .ci(gc[j]),
        .s (ss[GROUP_W*j +: GROUP_W]),
        .p (gp[j]),
        .g (gg[j]),
        .c3(c3[j])
      );
    end
    // sum-of-products group carries so no carry ripples through the stage
    always_comb begin
      logic t, x;
      t = 1'b0;
      x = 1'b0;
      gc = '0;
      gc[0] = pin.c;
      for (int j = 1; j <= GPS; j++) begin
        t = 1'b1;
        x = 1'b0;
        for (int i = j - 1; i >= 0; i--) begin
          x = x | (t & gg[i]);
          t = t & gp[i];
        end
        gc[j] = x | (t & pin.c);
      end
    end
    always_comb begin
      nxt[k] = pin;
      nxt[k].s[LO +: SW] = ss;
      nxt[k].c = gc[GPS];
      nxt[k].mc = c3[GPS-1];
    end
  end
  // the output stage only loads on a real result so outputs hold across bubbles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      zero_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) r[i] <= '0;
    end else if (adv) begin
      v <= vv[STAGES-1:0];
      for (int i = 0; i < STAGES; i++) if (i < STAGES - 1 || vv[i]) r[i] <= nxt[i];
      if (vv[STAGES-1]) zero_q <= ~|nxt[STAGES-1].s;
    end
  assign io.in_ready = adv;
  assign io.out_valid = v[STAGES-1];
  assign io.sum = r[STAGES-1].s;
  assign io.cout = r[STAGES-1].c;
  assign io.ovf = r[STAGES-1].c ^ r[STAGES-1].mc;
  assign io.zero = zero_q;
  assign io.out_tag = r[STAGES-1].tag;
endmodule
